// File: rtl/odyssey_video_gen.sv
// Odyssey video timing and spot generator.
//
// Walks a raster of H_TOTAL clocks by V_TOTAL lines, flags the horizontal and
// vertical blanking intervals, latches the two players' stick positions once
// per frame and decodes an 8x8 grid-pixel spot for each player. Every output
// is registered and describes the same raster position in the same cycle.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   Analog1XP1   P1 stick X, signed
//   Analog1YP1   P1 stick Y, signed
//   Analog1XP2   P2 stick X, signed
//   Analog1YP2   P2 stick Y, signed
//   hcount       clock within line, 0..H_TOTAL-1
//   vcount       line within frame, 0..V_TOTAL-1
//   HSync        high across the whole horizontal blank
//   VSync        high across the whole vertical blank
//   line_start   strobe at hcount == 0
//   frame_start  strobe at hcount == 0 and vcount == 0
//   p1_x .. p2_y latched unsigned spot positions
//   spot1_on     current pixel lies inside the P1 spot
//   spot2_on     current pixel lies inside the P2 spot
//   video        8'hFF where either spot is lit, else 8'h00
module odyssey_video_gen #(
    parameter int unsigned CLK_FREQ = 20_000_000,
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_TOTAL  = 1270,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned V_TOTAL  = 262,
    parameter int unsigned SPOT_W   = 8,
    parameter int unsigned SPOT_H   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  Analog1XP1,
    input  logic [7:0]  Analog1YP1,
    input  logic [7:0]  Analog1XP2,
    input  logic [7:0]  Analog1YP2,
    output logic [10:0] hcount,
    output logic [8:0]  vcount,
    output logic        HSync,
    output logic        VSync,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  p1_x,
    output logic [7:0]  p1_y,
    output logic [7:0]  p2_x,
    output logic [7:0]  p2_y,
    output logic        spot1_on,
    output logic        spot2_on,
    output logic [7:0]  video
);

    localparam logic [10:0] HLast   = 11'(H_TOTAL - 1);
    localparam logic [10:0] HAct    = 11'(H_ACTIVE);
    localparam logic [8:0]  VLast   = 9'(V_TOTAL - 1);
    localparam logic [8:0]  VAct    = 9'(V_ACTIVE);
    localparam logic [8:0]  SpotWm1 = 9'(SPOT_W - 1);
    localparam logic [8:0]  SpotHm1 = 9'(SPOT_H - 1);
    localparam logic [7:0]  PosMid  = 8'd128;

    // Catch timings that could never produce a visible raster.
    if (H_TOTAL <= H_ACTIVE || V_TOTAL <= V_ACTIVE || CLK_FREQ == 0) begin : g_param_check
        $error("odyssey_video_gen: blanking intervals must be non-empty");
    end

    // Raster position of the outputs currently presented. Held at the last
    // position during reset so the first released edge lands on (0,0).
    logic [10:0] pos_h_q, pos_h_d;
    logic [8:0]  pos_v_q, pos_v_d;

    logic [10:0] hcount_q;
    logic [8:0]  vcount_q;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [7:0]  p1_x_q, p1_x_d;
    logic [7:0]  p1_y_q, p1_y_d;
    logic [7:0]  p2_x_q, p2_x_d;
    logic [7:0]  p2_y_q, p2_y_d;
    logic        spot1_q, spot1_d;
    logic        spot2_q, spot2_d;
    logic        active_d;
    logic [7:0]  grid_x, grid_y;

    // True when g falls in [p, p+len_m1]. The end point is kept 9 bits wide so
    // spots near column/row 255 clip instead of wrapping to 0.
    function automatic logic covers(input logic [7:0] g, input logic [7:0] p,
                                    input logic [8:0] len_m1);
        logic [8:0] last;
        last = {1'b0, p} + len_m1;
        return ({1'b0, g} >= {1'b0, p}) && ({1'b0, g} <= last);
    endfunction

    always_comb begin
        pos_h_d = pos_h_q + 11'd1;
        pos_v_d = pos_v_q;
        if (pos_h_q == HLast) begin
            pos_h_d = 11'd0;
            pos_v_d = (pos_v_q == VLast) ? 9'd0 : pos_v_q + 9'd1;
        end

        hsync_d       = (pos_h_d >= HAct);
        vsync_d       = (pos_v_d >= VAct);
        line_start_d  = (pos_h_d == 11'd0);
        frame_start_d = line_start_d && (pos_v_d == 9'd0);

        // New positions are visible on the frame_start cycle itself.
        p1_x_d = p1_x_q;
        p1_y_d = p1_y_q;
        p2_x_d = p2_x_q;
        p2_y_d = p2_y_q;
        if (frame_start_d) begin
            p1_x_d = Analog1XP1 ^ 8'h80;
            p1_y_d = Analog1YP1 ^ 8'h80;
            p2_x_d = Analog1XP2 ^ 8'h80;
            p2_y_d = Analog1YP2 ^ 8'h80;
        end

        // Four clocks per grid pixel horizontally, one line per grid row.
        active_d = !hsync_d && !vsync_d;
        grid_x   = pos_h_d[9:2];
        grid_y   = pos_v_d[7:0];
        spot1_d  = active_d && covers(grid_x, p1_x_d, SpotWm1)
                            && covers(grid_y, p1_y_d, SpotHm1);
        spot2_d  = active_d && covers(grid_x, p2_x_d, SpotWm1)
                            && covers(grid_y, p2_y_d, SpotHm1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_h_q       <= HLast;
            pos_v_q       <= VLast;
            hcount_q      <= 11'd0;
            vcount_q      <= 9'd0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            p1_x_q        <= PosMid;
            p1_y_q        <= PosMid;
            p2_x_q        <= PosMid;
            p2_y_q        <= PosMid;
            spot1_q       <= 1'b0;
            spot2_q       <= 1'b0;
        end else begin
            pos_h_q       <= pos_h_d;
            pos_v_q       <= pos_v_d;
            hcount_q      <= pos_h_d;
            vcount_q      <= pos_v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            p1_x_q        <= p1_x_d;
            p1_y_q        <= p1_y_d;
            p2_x_q        <= p2_x_d;
            p2_y_q        <= p2_y_d;
            spot1_q       <= spot1_d;
            spot2_q       <= spot2_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign HSync       = hsync_q;
    assign VSync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign p1_x        = p1_x_q;
    assign p1_y        = p1_y_q;
    assign p2_x        = p2_x_q;
    assign p2_y        = p2_y_q;
    assign spot1_on    = spot1_q;
    assign spot2_on    = spot2_q;
    assign video       = (spot1_q || spot2_q) ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_odyssey_video_gen.sv
// Bench for odyssey_video_gen. Uses a shortened frame (full 1024-clock active
// width, fewer lines) so several frames fit in a short run.
module tb_odyssey_video_gen;

    localparam int HA    = 1024;
    localparam int HT    = 1040;
    localparam int VA    = 32;
    localparam int VT    = 36;
    localparam int SW    = 8;
    localparam int SH    = 8;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  ax1, ay1, ax2, ay2;
    logic [10:0] hcount;
    logic [8:0]  vcount;
    logic        HSync, VSync, line_start, frame_start;
    logic [7:0]  p1_x, p1_y, p2_x, p2_y;
    logic        spot1_on, spot2_on;
    logic [7:0]  video;

    int total = 0;
    int bad = 0;

    odyssey_video_gen #(
        .CLK_FREQ (20_000_000),
        .H_ACTIVE (HA),
        .H_TOTAL  (HT),
        .V_ACTIVE (VA),
        .V_TOTAL  (VT),
        .SPOT_W   (SW),
        .SPOT_H   (SH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Analog1XP1  (ax1),
        .Analog1YP1  (ay1),
        .Analog1XP2  (ax2),
        .Analog1YP2  (ay2),
        .hcount      (hcount),
        .vcount      (vcount),
        .HSync       (HSync),
        .VSync       (VSync),
        .line_start  (line_start),
        .frame_start (frame_start),
        .p1_x        (p1_x),
        .p1_y        (p1_y),
        .p2_x        (p2_x),
        .p2_y        (p2_y),
        .spot1_on    (spot1_on),
        .spot2_on    (spot2_on),
        .video       (video)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic rand_inputs();
        ax1 = 8'($urandom);
        ay1 = 8'($urandom);
        ax2 = 8'($urandom);
        ay2 = 8'($urandom);
    endtask

    // Expected output bundle for raster offset p (cycles since frame start).
    function automatic logic [65:0] expect_at(input int p, input int x1, input int y1,
                                              input int x2, input int y2);
        int h, v, gx, gy;
        bit act, s1, s2;
        h   = p % HT;
        v   = p / HT;
        gx  = h / 4;
        gy  = v;
        act = (h < HA) && (v < VA);
        s1  = act && gx >= x1 && gx <= x1 + SW - 1 && gy >= y1 && gy <= y1 + SH - 1;
        s2  = act && gx >= x2 && gx <= x2 + SW - 1 && gy >= y2 && gy <= y2 + SH - 1;
        return {11'(h), 9'(v), h >= HA, v >= VA, h == 0, p == 0,
                8'(x1), 8'(y1), 8'(x2), 8'(y2), s1, s2, (s1 || s2) ? 8'hFF : 8'h00};
    endfunction

    // Reference model: a frame offset counter plus latched positions.
    int mpos;
    int mx1, my1, mx2, my2;
    bit armed = 0;
    always begin
        logic        r;
        logic [7:0]  i1, j1, i2, j2;
        logic [65:0] want, got;
        @(posedge clk);
        r  = reset;
        i1 = ax1; j1 = ay1; i2 = ax2; j2 = ay2;
        #1;
        if (r) begin
            armed = 1;
            mpos  = -1;
            mx1 = 128; my1 = 128; mx2 = 128; my2 = 128;
            want  = {11'd0, 9'd0, 4'b0000, 8'd128, 8'd128, 8'd128, 8'd128, 2'b00, 8'h00};
        end else if (armed) begin
            mpos = (mpos + 1) % FRAME;
            if (mpos == 0) begin
                mx1 = int'(i1 ^ 8'h80); my1 = int'(j1 ^ 8'h80);
                mx2 = int'(i2 ^ 8'h80); my2 = int'(j2 ^ 8'h80);
            end
            want = expect_at(mpos, mx1, my1, mx2, my2);
        end
        if (armed) begin
            got = {hcount, vcount, HSync, VSync, line_start, frame_start,
                   p1_x, p1_y, p2_x, p2_y, spot1_on, spot2_on, video};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL model t=%0t got=%h expected=%h (h=%0d v=%0d)",
                         $time, got, want, hcount, vcount);
            end
        end
    end

    initial begin
        int ls_cnt, hs_cnt, vs_cnt, max_h, max_v, fs_extra;
        int s1_cnt, s1_hmin, s1_hmax, s1_vmin, s1_vmax, s2_cnt, s2_hmin, s2_left;
        int both_cnt, ff_cnt;
        bit wrap_line, wrap_frame;
        int prev_h, prev_v;
        logic [7:0] sx2, sy2;

        // P1 at (10,20), P2 at (252,4).
        ax1 = 8'h8A; ay1 = 8'h94; ax2 = 8'h7C; ay2 = 8'h84;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_hcount", hcount, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_p1_x", p1_x, 128);
        check("rst_video", video, 0);
        reset = 1'b0;

        ls_cnt = 0; hs_cnt = 0; vs_cnt = 0; max_h = 0; max_v = 0; fs_extra = 0;
        s1_cnt = 0; s1_hmin = 9999; s1_hmax = -1; s1_vmin = 9999; s1_vmax = -1;
        s2_cnt = 0; s2_hmin = 9999; s2_left = 0;
        wrap_line = 0; wrap_frame = 0; prev_h = -1; prev_v = -1;
        for (int cyc = 0; cyc <= FRAME; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
                check("first_frame_start", frame_start, 1);
                check("first_line_start", line_start, 1);
                check("first_hcount", hcount, 0);
                check("latch_p1_x", p1_x, 10);
                check("latch_p1_y", p1_y, 20);
                check("latch_p2_x", p2_x, 252);
            end
            if (cyc == 20000) check("hold_p1_x", p1_x, 10);
            if (cyc < FRAME) begin
                if (line_start) ls_cnt++;
                if (HSync) hs_cnt++;
                if (VSync) vs_cnt++;
                if (frame_start && cyc != 0) fs_extra++;
                if (int'(hcount) > max_h) max_h = int'(hcount);
                if (int'(vcount) > max_v) max_v = int'(vcount);
                if (spot1_on) begin
                    s1_cnt++;
                    if (int'(hcount) < s1_hmin) s1_hmin = int'(hcount);
                    if (int'(hcount) > s1_hmax) s1_hmax = int'(hcount);
                    if (int'(vcount) < s1_vmin) s1_vmin = int'(vcount);
                    if (int'(vcount) > s1_vmax) s1_vmax = int'(vcount);
                end
                if (spot2_on) begin
                    s2_cnt++;
                    if (int'(hcount) < s2_hmin) s2_hmin = int'(hcount);
                    if (hcount < 11'd16) s2_left++;
                end
            end
            if (prev_h == HT - 1 && prev_v == 0 && hcount == 11'd0 && vcount == 9'd1)
                wrap_line = 1;
            if (prev_h == HT - 1 && prev_v == VT - 1 && hcount == 11'd0 && vcount == 9'd0
                && frame_start)
                wrap_frame = 1;
            prev_h = int'(hcount);
            prev_v = int'(vcount);
            if (cyc == FRAME) begin
                check("frame2_start", frame_start, 1);
                check("frame2_p1_x", p1_x, 255);
                check("frame2_p1_y", p1_y, 255);
            end
            if (cyc < 30 * HT) rand_inputs();
            else begin
                ax1 = 8'h7F; ay1 = 8'h7F; ax2 = 8'h7F; ay2 = 8'h7F;
            end
        end
        check("line_start_count", ls_cnt, VT);
        check("hsync_count", hs_cnt, (HT - HA) * VT);
        check("vsync_count", vs_cnt, (VT - VA) * HT);
        check("extra_frame_start", fs_extra, 0);
        check("max_hcount", max_h, HT - 1);
        check("max_vcount", max_v, VT - 1);
        check("wrap_line", int'(wrap_line), 1);
        check("wrap_frame", int'(wrap_frame), 1);
        check("spot1_count", s1_cnt, 256);
        check("spot1_hmin", s1_hmin, 40);
        check("spot1_hmax", s1_hmax, 71);
        check("spot1_vmin", s1_vmin, 20);
        check("spot1_vmax", s1_vmax, 27);
        check("clip_count", s2_cnt, 128);
        check("clip_hmin", s2_hmin, 1008);
        check("clip_no_wrap", s2_left, 0);

        // Walk to (500,6) of frame 2, then reset mid-frame.
        for (int k = 0; k < 6 * HT + 500; k++) begin
            @(posedge clk); #1;
            rand_inputs();
        end
        check("pre_reset_h", hcount, 500);
        check("pre_reset_v", vcount, 6);
        reset = 1'b1;
        ax1 = 8'h80; ay1 = 8'h00;
        sx2 = 8'($urandom); sy2 = 8'($urandom);
        ax2 = sx2; ay2 = sy2;
        @(posedge clk); #1;
        check("midrst_hcount", hcount, 0);
        check("midrst_vcount", vcount, 0);
        check("midrst_line_start", line_start, 0);
        check("midrst_p1_x", p1_x, 128);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rel_frame_start", frame_start, 1);
        check("rel_hcount", hcount, 0);
        check("rel_p1_x", p1_x, 0);
        check("rel_p1_y", p1_y, 128);
        check("rel_p2_x", p2_x, int'(sx2 ^ 8'h80));
        check("rel_p2_y", p2_y, int'(sy2 ^ 8'h80));
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            rand_inputs();
        end

        // Both players at (100,2).
        reset = 1'b1;
        ax1 = 8'hE4; ay1 = 8'h82; ax2 = 8'hE4; ay2 = 8'h82;
        @(posedge clk); #1;
        reset = 1'b0;
        both_cnt = 0; ff_cnt = 0;
        for (int k = 0; k < 12 * HT; k++) begin
            @(posedge clk); #1;
            if (spot1_on && spot2_on) both_cnt++;
            if (video == 8'hFF) ff_cnt++;
            if (k > 0) rand_inputs();
        end
        check("overlap_both", both_cnt, 256);
        check("overlap_video", ff_cnt, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
